// File: rtl/ctech_lib_clk_gate_pkg.sv
// ctech_lib_clk_gate_pkg: FSM state encoding and counter width helper for the NOR clock-gate enable controller
package ctech_lib_clk_gate_pkg;
  typedef enum logic [1:0] {
    GATED     = 2'b00,
    WAKING    = 2'b01,
    ACTIVE    = 2'b10,
    IDLE_WAIT = 2'b11
  } cg_state_t;
  function automatic int cg_cnt_w(input int idle_cyc, input int wake_lat);
    return $clog2((idle_cyc > wake_lat ? idle_cyc : wake_lat) + 1);
  endfunction
endpackage

// File: rtl/ctech_lib_clk_gate_cnt.sv
// ctech_lib_clk_gate_cnt: clearable saturating up-counter with terminal-count flag (clk, rst_b, clr, inc -> tc)
module ctech_lib_clk_gate_cnt #(
  parameter int W  = 2,
  parameter int TC = 0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_b || clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end
  assign tc = cnt == W'(TC);
endmodule

// File: rtl/ctech_lib_clk_gate_en_ctrl.sv
// ctech_lib_clk_gate_en_ctrl: wake requests -> registered disable for a NOR clock gate (clk, rst_b, req, force_on -> clk_dis, clk_rdy, state_o)
module ctech_lib_clk_gate_en_ctrl
  import ctech_lib_clk_gate_pkg::*;
#(
  parameter int NUM_REQ  = 1,
  parameter int IDLE_CYC = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  output logic               clk_dis,
  output logic               clk_rdy,
  output logic [1:0]         state_o
);
  localparam int CNT_W   = cg_cnt_w(IDLE_CYC, WAKE_LAT);
  localparam int IDLE_TC = IDLE_CYC > 0 ? IDLE_CYC - 1 : 0;
  cg_state_t state;
  logic req_eff, wake_tc, idle_tc;
  assign req_eff = |req | force_on;
  assign state_o = state;
  // Counters are held clear outside their state, so every entry starts at zero.
  ctech_lib_clk_gate_cnt #(.W(CNT_W), .TC(WAKE_LAT - 1)) u_wake (
    .clk(clk), .rst_b(rst_b), .clr(state != WAKING), .inc(state == WAKING), .tc(wake_tc)
  );
  ctech_lib_clk_gate_cnt #(.W(CNT_W), .TC(IDLE_TC)) u_idle (
    .clk(clk), .rst_b(rst_b), .clr(state != IDLE_WAIT || req_eff), .inc(state == IDLE_WAIT), .tc(idle_tc)
  );
  // clk_dis only changes on posedge, while clk is high and the NOR output is already held low.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state   <= WAKING;
      clk_dis <= 1'b0;
      clk_rdy <= 1'b0;
    end else begin
      case (state)
        GATED: if (req_eff) begin
          state   <= WAKING;
          clk_dis <= 1'b0;
        end
        WAKING: if (wake_tc) begin
          clk_rdy <= 1'b1;
          state   <= req_eff ? ACTIVE : IDLE_WAIT;
        end
        ACTIVE: if (!req_eff) begin
          state   <= IDLE_CYC == 0 ? GATED : IDLE_WAIT;
          clk_dis <= IDLE_CYC == 0;
          clk_rdy <= IDLE_CYC != 0;
        end
        IDLE_WAIT: if (req_eff) state <= ACTIVE;
        else if (IDLE_CYC == 0 || idle_tc) begin
          state   <= GATED;
          clk_dis <= 1'b1;
          clk_rdy <= 1'b0;
        end
        default: begin
          state   <= WAKING;
          clk_dis <= 1'b0;
          clk_rdy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ctech_lib_clk_gate_en_ctrl.sv
// tb_ctech_lib_clk_gate_en_ctrl: randomized and directed checks against a count-based reference model
module tb_ctech_lib_clk_gate_en_ctrl;
  import ctech_lib_clk_gate_pkg::*;
  localparam int NR = 2, IC = 8, WL = 2;
  logic clk = 1'b0;
  logic rst_b = 1'b0, force_on = 1'b0;
  logic [NR-1:0] req = '0;
  logic clk_dis, clk_rdy, dis0, rdy0;
  logic [1:0] state_o, st0;
  int checks = 0, errors = 0;
  // Reference: gated flag, edges left until settled, consecutive idle edges while settled.
  bit m_gated = 1'b0, m_rdy = 1'b0;
  int m_wake_left = WL, m_idle = 0;
  always #5 clk = ~clk;
  ctech_lib_clk_gate_en_ctrl #(.NUM_REQ(NR), .IDLE_CYC(IC), .WAKE_LAT(WL)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .force_on(force_on),
    .clk_dis(clk_dis), .clk_rdy(clk_rdy), .state_o(state_o)
  );
  ctech_lib_clk_gate_en_ctrl #(.NUM_REQ(NR), .IDLE_CYC(0), .WAKE_LAT(WL)) dut0 (
    .clk(clk), .rst_b(rst_b), .req(req), .force_on(force_on),
    .clk_dis(dis0), .clk_rdy(rdy0), .state_o(st0)
  );
  function automatic logic [1:0] exp_state();
    return m_gated ? GATED : !m_rdy ? WAKING : m_idle == 0 ? ACTIVE : IDLE_WAIT;
  endfunction
  task automatic tick(input logic [NR-1:0] r, input logic f, input logic rb);
    bit r_eff;
    @(negedge clk);
    req = r; force_on = f; rst_b = rb;
    r_eff = (|r) | f;
    @(posedge clk);
    if (!rb) begin
      m_gated = 0; m_rdy = 0; m_wake_left = WL; m_idle = 0;
    end else if (m_gated) begin
      if (r_eff) begin m_gated = 0; m_wake_left = WL; end
    end else if (!m_rdy) begin
      m_wake_left--;
      if (m_wake_left == 0) begin m_rdy = 1; m_idle = r_eff ? 0 : 1; end
    end else if (r_eff) m_idle = 0;
    else begin
      m_idle++;
      if (m_idle >= IC + 1) begin m_gated = 1; m_rdy = 0; m_idle = 0; end
    end
    #1;
  endtask
  always @(negedge clk) begin
    if (clk_rdy === 1'b1 && clk_dis === 1'b1) begin
      errors++;
      $display("FAIL rdy_while_dis t=%0t dis=%b rdy=%b need rdy=0", $time, clk_dis, clk_rdy);
    end
  end
  always @(clk_dis) begin
    if ($time > 0 && clk !== 1'b1) begin
      errors++;
      $display("FAIL dis_edge t=%0t clk=%b need clk=1 when clk_dis changes", $time, clk);
    end
  end
  task automatic test_reset();
    tick('0, 0, 0);
    tick('0, 0, 0);
    checks++;
    if ({clk_dis, clk_rdy, state_o} !== {1'b0, 1'b0, WAKING}) begin
      errors++;
      $display("FAIL reset got dis=%b rdy=%b st=%0d need 0 0 %0d", clk_dis, clk_rdy, state_o, WAKING);
    end
    for (int i = 1; i <= 12; i++) begin
      tick('0, 0, 1);
      checks++;
      if ({clk_dis, clk_rdy, state_o} !== {m_gated, m_rdy, exp_state()}) begin
        errors++;
        $display("FAIL reset_idle edge=%0d got dis=%b rdy=%b st=%0d need %b %b %0d", i, clk_dis, clk_rdy, state_o, m_gated, m_rdy, exp_state());
      end
      if (i == 2 || i == 3) begin
        checks++;
        if ({dis0, rdy0} !== (i == 2 ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL idle0 edge=%0d got dis=%b rdy=%b need %b", i, dis0, rdy0, (i == 2 ? 2'b01 : 2'b10));
        end
      end
    end
    checks++;
    if ({clk_dis, state_o} !== {1'b1, GATED}) begin
      errors++;
      $display("FAIL reset_gated got dis=%b st=%0d need 1 %0d", clk_dis, state_o, GATED);
    end
  endtask
  task automatic test_wake();
    for (int i = 1; i <= 4; i++) begin
      tick(2'b01, 0, 1);
      checks++;
      if ({clk_dis, clk_rdy, state_o} !== {m_gated, m_rdy, exp_state()}) begin
        errors++;
        $display("FAIL wake edge=%0d got dis=%b rdy=%b st=%0d need %b %b %0d", i, clk_dis, clk_rdy, state_o, m_gated, m_rdy, exp_state());
      end
    end
    checks++;
    if (state_o !== ACTIVE) begin
      errors++;
      $display("FAIL wake_active got st=%0d need %0d", state_o, ACTIVE);
    end
  endtask
  task automatic test_idle_reassert();
    for (int i = 1; i <= 20; i++) begin
      tick((i == 7) ? 2'b10 : 2'b00, 0, 1);
      checks++;
      if ({clk_dis, clk_rdy, state_o} !== {m_gated, m_rdy, exp_state()}) begin
        errors++;
        $display("FAIL reassert edge=%0d got dis=%b rdy=%b st=%0d need %b %b %0d", i, clk_dis, clk_rdy, state_o, m_gated, m_rdy, exp_state());
      end
      if (i <= 15) begin
        checks++;
        if (clk_dis !== 1'b0) begin
          errors++;
          $display("FAIL reassert_hold edge=%0d got dis=%b need 0", i, clk_dis);
        end
      end
    end
  endtask
  task automatic test_pulse();
    for (int i = 1; i <= 14; i++) begin
      tick((i == 1) ? 2'b01 : 2'b00, 0, 1);
      checks++;
      if ({clk_dis, clk_rdy, state_o} !== {m_gated, m_rdy, exp_state()}) begin
        errors++;
        $display("FAIL pulse edge=%0d got dis=%b rdy=%b st=%0d need %b %b %0d", i, clk_dis, clk_rdy, state_o, m_gated, m_rdy, exp_state());
      end
    end
  endtask
  task automatic test_force();
    for (int i = 1; i <= 100; i++) begin
      tick('0, 1, 1);
      checks++;
      if (clk_dis !== 1'b0 || {clk_rdy, state_o} !== {m_rdy, exp_state()}) begin
        errors++;
        $display("FAIL force edge=%0d got dis=%b rdy=%b st=%0d need 0 %b %0d", i, clk_dis, clk_rdy, state_o, m_rdy, exp_state());
      end
    end
    for (int i = 1; i <= 12; i++) begin
      tick('0, 0, 1);
      checks++;
      if ({clk_dis, clk_rdy, state_o} !== {m_gated, m_rdy, exp_state()}) begin
        errors++;
        $display("FAIL release edge=%0d got dis=%b rdy=%b st=%0d need %b %b %0d", i, clk_dis, clk_rdy, state_o, m_gated, m_rdy, exp_state());
      end
    end
  endtask
  task automatic test_reset_gated();
    tick('0, 0, 0);
    checks++;
    if ({clk_dis, clk_rdy, state_o} !== {1'b0, 1'b0, WAKING}) begin
      errors++;
      $display("FAIL rst_gated got dis=%b rdy=%b st=%0d need 0 0 %0d", clk_dis, clk_rdy, state_o, WAKING);
    end
    for (int i = 1; i <= 3; i++) begin
      tick('0, 0, 1);
      checks++;
      if ({clk_dis, clk_rdy, state_o} !== {m_gated, m_rdy, exp_state()}) begin
        errors++;
        $display("FAIL rst_recover edge=%0d got dis=%b rdy=%b st=%0d need %b %b %0d", i, clk_dis, clk_rdy, state_o, m_gated, m_rdy, exp_state());
      end
    end
  endtask
  task automatic test_random();
    logic [NR-1:0] r = '0;
    logic f = 1'b0;
    int hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        r = ($urandom_range(0, 2) == 0) ? NR'($urandom) : '0;
        f = $urandom_range(0, 9) == 0;
        hold = $urandom_range(1, 14);
      end
      hold--;
      tick(r, f, $urandom_range(0, 59) != 0);
      checks++;
      if ({clk_dis, clk_rdy, state_o} !== {m_gated, m_rdy, exp_state()}) begin
        errors++;
        $display("FAIL random i=%0d got dis=%b rdy=%b st=%0d need %b %b %0d", i, clk_dis, clk_rdy, state_o, m_gated, m_rdy, exp_state());
      end
    end
  endtask
  initial begin
    test_reset();
    test_wake();
    test_idle_reassert();
    test_pulse();
    test_force();
    test_reset_gated();
    for (int i = 0; i < 12; i++) tick('0, 0, 1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
